// File: rtl/alu_pkg.sv
// Shared encodings for the serial add/subtract datapath: operation codes and FSM states.
package alu_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : alu_pkg

// File: rtl/chunk_addsub.sv
// Combinational K-bit add/subtract slice with chained carry/borrow and the carry/borrow into its MSB.
module chunk_addsub
   import alu_pkg::*;
#(
   parameter int K = 8
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         op,
   input  logic         ci,
   output logic [K-1:0] s,
   output logic         co,
   output logic         msb_ci
);

   logic [K:0] full;

   // For subtract the extra top bit wraps to 1 exactly when a borrow leaves the slice.
   always_comb begin
      if (op == OP_SUB) full = {1'b0, a} - {1'b0, b} - (K+1)'(ci);
      else              full = {1'b0, a} + {1'b0, b} + (K+1)'(ci);
   end

   assign s  = full[K-1:0];
   assign co = full[K];

   generate
      if (K == 1) begin : g_single
         assign msb_ci = ci;
      end else begin : g_low
         logic [K-1:0] low;
         always_comb begin
            if (op == OP_SUB) low = {1'b0, a[K-2:0]} - {1'b0, b[K-2:0]} - K'(ci);
            else              low = {1'b0, a[K-2:0]} + {1'b0, b[K-2:0]} + K'(ci);
         end
         assign msb_ci = low[K-1];
      end
   endgenerate

endmodule : chunk_addsub

// File: rtl/serial_addsub.sv
// Multi-cycle N-bit adder/subtractor processing K bits per cycle with valid/ready handshakes.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module serial_addsub
   import alu_pkg::*;
#(
   parameter int N = 32,
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         op,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] res,
   output logic         cout,
   output logic         overflow,
   output logic         zero
);

   localparam int NC = N / K;
   localparam int IW = (NC > 1) ? $clog2(NC) : 1;

   generate
      if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_bad_cfg
         $error("serial_addsub: N must be a positive integer multiple of K");
      end
   endgenerate

   state_t         state;
   logic [IW-1:0]  idx;
   logic [N-1:0]   a_r;
   logic [N-1:0]   b_r;
   logic           op_r;
   logic           carry;
   logic [N-1:0]   acc;

   logic [K-1:0]   sum;
   logic           co;
   logic           msb_ci;
   logic           ovf;
   logic [N-1:0]   wrap_res;
   logic [N-1:0]   final_res;

   chunk_addsub #(.K(K)) u_chunk (
      .a      (a_r[idx*K +: K]),
      .b      (b_r[idx*K +: K]),
      .op     (op_r),
      .ci     (carry),
      .s      (sum),
      .co     (co),
      .msb_ci (msb_ci)
   );

   // Only meaningful on the last chunk, where the slice MSB is bit N-1.
   assign ovf = msb_ci ^ co;

   // NOTE: every variable assigned in always_comb gets a full default first so no latch is inferred.
   always_comb begin
      wrap_res          = acc;
      wrap_res[N-1 -: K] = sum;
`ifdef SERIAL_ADDSUB_SAT_EN
      // On overflow the true result carries the sign of a for both add and subtract.
      if (ovf) final_res = a_r[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else     final_res = wrap_res;
`else
      final_res = wrap_res;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         res       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         idx       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         op_r      <= OP_ADD;
         carry     <= 1'b0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  op_r     <= op;
                  carry    <= cin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               acc[idx*K +: K] <= sum;
               carry           <= co;
               if (idx == IW'(NC - 1)) begin
                  res       <= final_res;
                  cout      <= co;
                  overflow  <= ovf;
                  zero      <= (final_res == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule : serial_addsub
